// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// State encoding and memory geometry shared with the CPU.
package imem_loader_pkg;

  localparam int INSTR_W    = 32;
  localparam int IMEM_DEPTH = 256;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    WRITE   = 3'd1,
    ADVANCE = 3'd2,
    HOLD    = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } ld_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams host words into CPU instruction memory,
// holding the CPU in reset until the program is loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_W   = INSTR_W,
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int CNT_W    = 9,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              cpu_rst,
  output logic              cpu_enable,
  output logic              imw,
  output logic [DATA_W-1:0] itw,
  output logic              cnt_strobe,
  output logic [CNT_W-1:0]  word_count,
  output logic              load_done,
  output logic              overflow
);

  localparam int HW =
    (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [HW-1:0]    HOLD_C  = HW'(RST_HOLD);
  localparam logic [HW-1:0]    HOLD_1  = HW'(1);

  ld_state_t     state;
  logic          last;
  logic [HW-1:0] hold;

  // Load sequencer; every output is registered with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT;
      s_ready    <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_enable <= 1'b0;
      imw        <= 1'b0;
      itw        <= '0;
      cnt_strobe <= 1'b0;
      word_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      last       <= 1'b0;
      hold       <= '0;
    end else begin
      imw        <= 1'b0;
      cnt_strobe <= 1'b0;
      unique case (state)
        WAIT: begin
          cpu_rst    <= 1'b1;
          cpu_enable <= 1'b0;
          load_done  <= 1'b0;
          if (s_valid && s_ready) begin
            itw     <= s_data;
            last    <= s_last;
            s_ready <= 1'b0;
            imw     <= 1'b1;
            state   <= WRITE;
          end else begin
            s_ready <= 1'b1;
          end
        end
        WRITE: begin
          cnt_strobe <= 1'b1;
          word_count <= word_count + 1'b1;
          state      <= ADVANCE;
        end
        ADVANCE: begin
          if (last) begin
            hold  <= HOLD_C;
            state <= HOLD;
          end else if (word_count == DEPTH_C) begin
            overflow <= 1'b1;
            state    <= ERROR;
          end else begin
            s_ready <= 1'b1;
            state   <= WAIT;
          end
        end
        HOLD: begin
          if (hold <= HOLD_1) begin
            cpu_rst    <= 1'b0;
            cpu_enable <= 1'b1;
            load_done  <= 1'b1;
            state      <= RUN;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            cpu_rst    <= 1'b1;
            cpu_enable <= 1'b0;
            load_done  <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
            s_ready    <= 1'b1;
            state      <= WAIT;
          end
        end
        ERROR: begin
          if (reload) begin
            word_count <= '0;
            overflow   <= 1'b0;
            s_ready    <= 1'b1;
            state      <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random loads checked against a queue model
// of the host program, plus directed boundary cases.
module tb_imem_loader;

  localparam int DW  = 32;
  localparam int D   = 256;
  localparam int CW  = 9;
  localparam int RH  = 4;
  localparam int D4  = 4;
  localparam int CW4 = 3;
  localparam int RH4 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          reload = 1'b0;
  logic          s_ready, cpu_rst, cpu_enable, imw, cnt_strobe;
  logic          load_done, overflow;
  logic [DW-1:0] itw;
  logic [CW-1:0] word_count;

  logic           rst4 = 1'b1;
  logic           s_valid4 = 1'b0;
  logic [DW-1:0]  s_data4 = '0;
  logic           s_last4 = 1'b0;
  logic           reload4 = 1'b0;
  logic           s_ready4, cpu_rst4, cpu_enable4, imw4, cnt_strobe4;
  logic           load_done4, overflow4;
  logic [DW-1:0]  itw4;
  logic [CW4-1:0] word_count4;

  imem_loader #(
    .DATA_W(DW), .DEPTH(D), .CNT_W(CW), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .reload(reload),
    .cpu_rst(cpu_rst), .cpu_enable(cpu_enable),
    .imw(imw), .itw(itw), .cnt_strobe(cnt_strobe),
    .word_count(word_count), .load_done(load_done),
    .overflow(overflow)
  );

  imem_loader #(
    .DATA_W(DW), .DEPTH(D4), .CNT_W(CW4), .RST_HOLD(RH4)
  ) dut4 (
    .clk(clk), .rst(rst4),
    .s_valid(s_valid4), .s_ready(s_ready4),
    .s_data(s_data4), .s_last(s_last4),
    .reload(reload4),
    .cpu_rst(cpu_rst4), .cpu_enable(cpu_enable4),
    .imw(imw4), .itw(itw4), .cnt_strobe(cnt_strobe4),
    .word_count(word_count4), .load_done(load_done4),
    .overflow(overflow4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed write-port activity.
  logic [DW-1:0] wr_q[$];
  int            wr_cyc[$];
  int            st_cyc[$];
  int            both = 0;
  int            last_rst_cyc = 0;
  logic [DW-1:0] wr4_q[$];
  int            st4_n = 0;
  int            both4 = 0;
  int            en4_seen = 0;

  always @(negedge clk) begin
    if (imw) begin
      wr_q.push_back(itw);
      wr_cyc.push_back(cyc);
    end
    if (cnt_strobe) st_cyc.push_back(cyc);
    if (imw && cnt_strobe) both++;
    if (cpu_rst) last_rst_cyc = cyc;
    if (imw4) wr4_q.push_back(itw4);
    if (cnt_strobe4) st4_n++;
    if (imw4 && cnt_strobe4) both4++;
    if (cpu_enable4) en4_seen++;
  end

  function automatic void clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    st_cyc.delete();
    both = 0;
  endfunction

  int hs_cyc = 0;

  task automatic send(input logic [DW-1:0] d, input logic l,
                      output bit ok);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = s_ready;
    if (ok) hs_cyc = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
    s_last  = 1'($urandom);
  endtask

  task automatic send4(input logic [DW-1:0] d, input logic l,
                       output bit ok);
    int t = 0;
    s_valid4 = 1'b1;
    s_data4  = d;
    s_last4  = l;
    while (!s_ready4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = s_ready4;
    @(negedge clk);
    s_valid4 = 1'b0;
    s_data4  = $urandom;
    s_last4  = 1'($urandom);
  endtask

  task automatic wait_run(input string tag);
    int t = 0;
    while (!load_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(load_done), 64'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_run4(input string tag);
    int t = 0;
    while (!load_done4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(load_done4), 64'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
  endtask

  // Compare observed writes against the program sent.
  task automatic check_prog(input string tag,
                            input logic [DW-1:0] exp_q[$]);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    check({tag, "_nstb"}, 64'(st_cyc.size()), 64'(exp_q.size()));
    check({tag, "_both"}, 64'(both), 64'd0);
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_data"}, 64'(wr_q[i]), 64'(exp_q[i]));
  endtask

  logic [DW-1:0] prog3[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] w4[$];
  bit            ok;
  int            hs0;
  int            n;

  initial begin
    prog3 = '{32'h20010005, 32'h20020003, 32'h00221820};
    #2;
    rst  = 1'b0;
    rst4 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_cpu_en", 64'(cpu_enable), 64'd0);
    check("rst_imw", 64'(imw), 64'd0);
    check("rst_strobe", 64'(cnt_strobe), 64'd0);
    check("rst_itw", 64'(itw), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    rst  = 1'b1;
    rst4 = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // Three-word load with s_valid held high.
    clear_mon();
    send(prog3[0], 1'b0, ok);
    hs0 = hs_cyc;
    send(prog3[1], 1'b0, ok);
    send(prog3[2], 1'b1, ok);
    wait_run("l3_run");
    check_prog("l3", prog3);
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++)
      check("l3_imw_cycle", 64'(wr_cyc[i] - hs0 + 1),
            64'(2 + 3 * i));
    for (int i = 0; i < 3 && i < st_cyc.size(); i++)
      check("l3_stb_cycle", 64'(st_cyc[i] - wr_cyc[i]), 64'd1);
    check("l3_wc", 64'(word_count), 64'd3);
    check("l3_en", 64'(cpu_enable), 64'd1);
    check("l3_cpu_rst", 64'(cpu_rst), 64'd0);
    check("l3_ovf", 64'(overflow), 64'd0);
    if (st_cyc.size() == 3)
      check("l3_rst_hold", 64'(last_rst_cyc - st_cyc[2]),
            64'(RH));

    // Reload from RUN with a single-word program.
    pulse_reload();
    check("rl_en", 64'(cpu_enable), 64'd0);
    check("rl_wc", 64'(word_count), 64'd0);
    check("rl_cpu_rst", 64'(cpu_rst), 64'd1);
    clear_mon();
    send(32'hFFFFFFFF, 1'b1, ok);
    wait_run("rl_run");
    rq = '{32'hFFFFFFFF};
    check_prog("rl", rq);
    check("rl_wc1", 64'(word_count), 64'd1);

    // Host stall between words 1 and 2.
    pulse_reload();
    clear_mon();
    send(prog3[0], 1'b0, ok);
    for (int t = 0; t < 10 && !s_ready; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("stall_ready", 64'(s_ready), 64'd1);
    end
    check("stall_nwr", 64'(wr_q.size()), 64'd1);
    send(prog3[1], 1'b0, ok);
    send(prog3[2], 1'b1, ok);
    wait_run("stall_run");
    check_prog("stall", prog3);

    // Asynchronous reset during WRITE of word 2.
    pulse_reload();
    clear_mon();
    send(prog3[0], 1'b0, ok);
    s_valid = 1'b1;
    s_data  = prog3[1];
    s_last  = 1'b0;
    for (int t = 0; t < 10 && !s_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    check("ar_pre_imw", 64'(imw), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_imw", 64'(imw), 64'd0);
    check("ar_stb", 64'(cnt_strobe), 64'd0);
    check("ar_cpu_rst", 64'(cpu_rst), 64'd1);
    check("ar_wc", 64'(word_count), 64'd0);
    check("ar_en", 64'(cpu_enable), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    send(prog3[0], 1'b0, ok);
    send(prog3[1], 1'b0, ok);
    send(prog3[2], 1'b1, ok);
    wait_run("ar_run");
    check_prog("ar", prog3);
    check("ar_wc3", 64'(word_count), 64'd3);

    // Random programs, random stalls, ignored reload pulses.
    for (int it = 0; it < 8; it++) begin
      pulse_reload();
      clear_mon();
      rq.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) rq.push_back($urandom);
      for (int i = 0; i < n; i++) begin
        send(rq[i], (i == n - 1), ok);
        if ($urandom_range(0, 3) == 0) begin
          reload = 1'b1;
          @(negedge clk);
          reload = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_run("rnd_run");
      check_prog("rnd", rq);
      check("rnd_wc", 64'(word_count), 64'(n));
      check("rnd_ovf", 64'(overflow), 64'd0);
    end

    // DEPTH=4 build: five words without s_last overflow.
    wr4_q.delete();
    w4.delete();
    for (int i = 0; i < 5; i++) w4.push_back($urandom);
    for (int i = 0; i < 5; i++) begin
      send4(w4[i], 1'b0, ok);
      if (i == 4) check("ovf_w5_accepted", 64'(ok), 64'd0);
    end
    #1;
    check("ovf_nwr", 64'(wr4_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr4_q.size(); i++)
      check("ovf_data", 64'(wr4_q[i]), 64'(w4[i]));
    check("ovf_flag", 64'(overflow4), 64'd1);
    check("ovf_ready", 64'(s_ready4), 64'd0);
    check("ovf_en_seen", 64'(en4_seen), 64'd0);
    check("ovf_cpu_rst", 64'(cpu_rst4), 64'd1);
    check("ovf_wc", 64'(word_count4), 64'd4);
    check("ovf_both", 64'(both4), 64'd0);

    // Reload out of ERROR, then exact fill with s_last on word 4.
    reload4 = 1'b1;
    @(negedge clk);
    reload4 = 1'b0;
    #1;
    check("err_rl_ovf", 64'(overflow4), 64'd0);
    check("err_rl_wc", 64'(word_count4), 64'd0);
    wr4_q.delete();
    st4_n = 0;
    for (int i = 0; i < 4; i++) send4(w4[4 - i], (i == 3), ok);
    wait_run4("fill_run");
    check("fill_nwr", 64'(wr4_q.size()), 64'd4);
    check("fill_nstb", 64'(st4_n), 64'd4);
    for (int i = 0; i < 4 && i < wr4_q.size(); i++)
      check("fill_data", 64'(wr4_q[i]), 64'(w4[4 - i]));
    check("fill_ovf", 64'(overflow4), 64'd0);
    check("fill_wc", 64'(word_count4), 64'd4);
    check("fill_en", 64'(cpu_enable4), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side sequencer for one CPU instance's instruction-memory load port. It drives the ins_mem_write, instruction_to_write and counter strobe inputs, plus the CPU's reset and enable.
- Accepts a stream of 32-bit instruction words from a host or boot source over a valid/ready handshake. It writes the words in order while holding the CPU in reset, then releases the CPU to run.
- One instance sits beside each CPU in the network top level.

Parameters:
- DATA_W, 32, instruction word width
- DEPTH, 256, instruction memory capacity in words
- CNT_W, 9, word-count width; must satisfy 2**CNT_W > DEPTH
- RST_HOLD, 4, cycles the CPU reset stays asserted after the last write

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- s_valid  input  1  host word valid
- s_ready  output  1  loader can accept a word
- s_data  input  DATA_W  instruction word
- s_last  input  1  marks the final word of the program
- reload  input  1  request a new load (sampled only in RUN or ERROR)
- cpu_rst  output  1  active-high reset to CPU
- cpu_enable  output  1  CPU enable
- imw  output  1  ins_mem_write strobe
- itw  output  DATA_W  instruction_to_write
- cnt_strobe  output  1  counter-advance pulse to CPU
- word_count  output  CNT_W  words written this load
- load_done  output  1  high while in RUN
- overflow  output  1  sticky error; cleared by reload or reset

Behaviour:
- Reset (rst=0, asynchronous):
  - state=WAIT, cpu_rst=1, cpu_enable=0.
  - imw=0, cnt_strobe=0, itw=0, word_count=0, overflow=0.
  - s_ready=1 after the first clock edge with rst=1; 0 while rst=0.
- States: WAIT, WRITE, ADVANCE, HOLD, RUN, ERROR. All outputs are registered.
- WAIT:
  - s_ready=1, cpu_rst=1, cpu_enable=0.
  - On s_valid&&s_ready: capture s_data into itw and s_last into a last flag; go to WRITE.
- WRITE (1 cycle): imw=1, itw stable; go to ADVANCE.
- ADVANCE (1 cycle):
  - cnt_strobe=1, itw still stable, word_count+1.
  - If last flag set: go to HOLD and load the hold counter with RST_HOLD.
  - Else if word_count+1==DEPTH: go to ERROR, overflow=1.
  - Else: go to WAIT.
- Throughput: 1 word per 3 cycles. s_ready is low in WRITE and ADVANCE.
- HOLD:
  - cpu_rst=1, s_ready=0.
  - Decrement the hold counter; at 0 go to RUN.
  - cpu_rst stays high exactly RST_HOLD cycles after ADVANCE.
- RUN:
  - cpu_rst=0, cpu_enable=1, load_done=1, s_ready=0.
  - reload=1: next cycle go to WAIT with cpu_rst=1, cpu_enable=0, word_count=0, overflow=0.
- ERROR:
  - cpu_rst=1, cpu_enable=0, s_ready=0, overflow=1.
  - Host data is ignored.
  - reload returns to WAIT and clears word_count and overflow.
- Word-count boundaries:
  - A word with s_last written at word_count==DEPTH-1 is legal: the load completes normally, no overflow.
  - Word DEPTH+1 can never be written.
- Handshake and input sampling:
  - s_data and s_last are sampled only on the handshake cycle.
  - A deasserted s_valid in WAIT simply stalls; no timeout.
  - reload is ignored in WAIT, WRITE, ADVANCE and HOLD; the load in progress is not aborted.
- Asynchronous reset during any state, including mid-WRITE: imw and cnt_strobe drop immediately. The partial load is discarded, so the host must restart from word 0.
- imw and cnt_strobe are never high in the same cycle, and each is high for exactly one cycle per word.

Decomposition:
- Shared package holds:
  - state encoding localparams: WAIT=3'd0, WRITE=3'd1, ADVANCE=3'd2, HOLD=3'd3, RUN=3'd4, ERROR=3'd5
  - INSTR_W=32 and IMEM_DEPTH=256, shared with the CPU instruction memory.
- No sub-module. The RST_HOLD down-counter is small enough to stay inline with the FSM.

Test Plan:
- 3-word load: stream 0x20010005, 0x20020003, 0x00221820 (last), with s_valid held high.
  - Required: imw pulses at cycles 2, 5, 8 after the first handshake, carrying those words in order.
  - cnt_strobe follows each imw by one cycle.
  - word_count reaches 3; cpu_rst falls 4 cycles after the final cnt_strobe; cpu_enable=1 and load_done=1.
- Host stall: gap s_valid low for 10 cycles between words 1 and 2.
  - Required: no extra imw or cnt_strobe pulses, s_ready stays 1, final memory contents identical to the no-stall case.
- Overflow: DEPTH=4 build, send 5 words with no s_last.
  - Required: 4 writes, then ERROR with overflow=1 and s_ready=0.
  - Word 5 never appears on imw; cpu_enable stays 0.
- Exact fill: DEPTH=4, s_last on word 4.
  - Required: RUN reached, overflow=0, word_count=4.
- Reload: in RUN, pulse reload, then load 1 word 0xFFFFFFFF (last).
  - Required: cpu_enable drops the next cycle and word_count clears to 0.
  - Then 1 write occurs, followed by RUN again.
- Async reset mid-load: drop rst during WRITE of word 2.
  - Required: imw=0 immediately, cpu_rst=1, word_count=0.
  - A full reload after reset completes normally.
